timer_regs: RTL and testbench

Register file and counter core of the APB timer. It sits directly downstream of the APB slave FSM. It consumes the FSM's one-cycle `wr_en`/`rd_en` strobes together with the APB address, data and strobe lines, and returns read data plus a combinational error flag that the FSM turns into `tim_pslverr`. It holds the 64-bit up-counter, its prescaler, the 64-bit compare, and the interrupt logic.

---
 rtl/timer_regs.sv | 195 +++++++++++++++++++
 tb/tb_timer_regs.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_regs.sv
// APB timer register file: 64-bit prescaled up-counter, 64-bit compare and interrupt.
// Optional debug halt (THCSR at 0x1C) is built only when TIMER_HALT_EN is defined.
module timer_regs (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [11:0] tim_paddr,
    input  logic [31:0] tim_pwdata,
    input  logic [3:0]  tim_pstrb,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic        dbg_mode,
    output logic [31:0] tim_prdata,
    output logic        reg_error_flag,
    output logic        tim_int
);

    localparam logic [9:0] WordTcr   = 10'd0;
    localparam logic [9:0] WordTdr0  = 10'd1;
    localparam logic [9:0] WordTdr1  = 10'd2;
    localparam logic [9:0] WordTcmp0 = 10'd3;
    localparam logic [9:0] WordTcmp1 = 10'd4;
    localparam logic [9:0] WordTier  = 10'd5;
    localparam logic [9:0] WordTisr  = 10'd6;
    localparam logic [9:0] WordThcsr = 10'd7;

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    logic        timer_en_q, timer_en_d;
    logic        div_en_q, div_en_d;
    logic [3:0]  div_val_q, div_val_d;
    logic [63:0] cnt_q, cnt_d;
    logic [7:0]  pre_q, pre_d;
    logic [63:0] cmp_q, cmp_d;
    logic        int_en_q, int_en_d;
    logic        int_st_q, int_st_d;
    logic        tim_int_q, tim_int_d;

    logic [9:0]  word;
    logic        sel_tcr, sel_tdr0, sel_tdr1, sel_tcmp0, sel_tcmp1, sel_tier, sel_tisr;
    logic        tcr_ten, tcr_den, tcr_err, wr_ok, int_clr, tick, halted;
    logic [3:0]  tcr_dval;
    logic [8:0]  pre_period;
    logic [31:0] thcsr_rd, rd_data;

    assign word      = tim_paddr[11:2];
    assign sel_tcr   = (word == WordTcr);
    assign sel_tdr0  = (word == WordTdr0);
    assign sel_tdr1  = (word == WordTdr1);
    assign sel_tcmp0 = (word == WordTcmp0);
    assign sel_tcmp1 = (word == WordTcmp1);
    assign sel_tier  = (word == WordTier);
    assign sel_tisr  = (word == WordTisr);

`ifdef TIMER_HALT_EN
    logic halt_req_q, halt_req_d, halt_ack_q, halt_ack_d;
    logic unused_addr;

    assign unused_addr = ^tim_paddr[1:0];
    assign halted      = halt_ack_q;
    assign thcsr_rd    = {30'h0, halt_ack_q, halt_req_q};

    always_comb begin
        halt_req_d = halt_req_q;
        if (wr_ok && (word == WordThcsr) && tim_pstrb[0]) begin
            halt_req_d = tim_pwdata[0];
        end
        halt_ack_d = dbg_mode & halt_req_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            halt_req_q <= 1'b0;
            halt_ack_q <= 1'b0;
        end else begin
            halt_req_q <= halt_req_d;
            halt_ack_q <= halt_ack_d;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{tim_paddr[1:0], dbg_mode};
    assign halted        = 1'b0;
    assign thcsr_rd      = 32'h0;
`endif

    // TCR fields as they would look after this write, honouring byte strobes
    always_comb begin
        tcr_ten  = tim_pstrb[0] ? tim_pwdata[0]    : timer_en_q;
        tcr_den  = tim_pstrb[0] ? tim_pwdata[1]    : div_en_q;
        tcr_dval = tim_pstrb[1] ? tim_pwdata[11:8] : div_val_q;
        tcr_err  = sel_tcr & ((tcr_dval > 4'd8) |
                   (timer_en_q & ((tcr_den != div_en_q) | (tcr_dval != div_val_q))));
    end

    assign reg_error_flag = wr_en & tcr_err;
    assign wr_ok          = wr_en & ~tcr_err;
    assign pre_period     = 9'd1 << div_val_q;
    assign tick           = ~div_en_q | ({1'b0, pre_q} == (pre_period - 9'd1));

    // Software writes take priority over counting; disabling clears the count
    always_comb begin
        cnt_d = cnt_q;
        pre_d = pre_q;
        if (wr_ok && sel_tcr && timer_en_q && !tcr_ten) begin
            cnt_d = '0;
            pre_d = '0;
        end else if (wr_ok && sel_tdr0) begin
            cnt_d[31:0] = merge(cnt_q[31:0], tim_pwdata, tim_pstrb);
            pre_d       = '0;
        end else if (wr_ok && sel_tdr1) begin
            cnt_d[63:32] = merge(cnt_q[63:32], tim_pwdata, tim_pstrb);
            pre_d        = '0;
        end else if (timer_en_q && !halted) begin
            if (tick) begin
                cnt_d = cnt_q + 64'd1;
                pre_d = '0;
            end else begin
                pre_d = pre_q + 8'd1;
            end
        end
    end

    always_comb begin
        timer_en_d = timer_en_q;
        div_en_d   = div_en_q;
        div_val_d  = div_val_q;
        cmp_d      = cmp_q;
        int_en_d   = int_en_q;
        if (wr_ok) begin
            if (sel_tcr) begin
                timer_en_d = tcr_ten;
                div_en_d   = tcr_den;
                div_val_d  = tcr_dval;
            end
            if (sel_tcmp0) cmp_d[31:0]  = merge(cmp_q[31:0], tim_pwdata, tim_pstrb);
            if (sel_tcmp1) cmp_d[63:32] = merge(cmp_q[63:32], tim_pwdata, tim_pstrb);
            if (sel_tier && tim_pstrb[0]) int_en_d = tim_pwdata[0];
        end
        int_clr   = wr_ok & sel_tisr & tim_pstrb[0] & tim_pwdata[0];
        int_st_d  = (cnt_q == cmp_q) | (int_st_q & ~int_clr);
        tim_int_d = int_st_q & int_en_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timer_en_q <= 1'b0;
            div_en_q   <= 1'b0;
            div_val_q  <= 4'd1;
            cnt_q      <= '0;
            pre_q      <= '0;
            cmp_q      <= '1;
            int_en_q   <= 1'b0;
            int_st_q   <= 1'b0;
            tim_int_q  <= 1'b0;
        end else begin
            timer_en_q <= timer_en_d;
            div_en_q   <= div_en_d;
            div_val_q  <= div_val_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            cmp_q      <= cmp_d;
            int_en_q   <= int_en_d;
            int_st_q   <= int_st_d;
            tim_int_q  <= tim_int_d;
        end
    end

    always_comb begin
        rd_data = 32'h0;
        case (word)
            WordTcr:   rd_data = {20'h0, div_val_q, 6'h0, div_en_q, timer_en_q};
            WordTdr0:  rd_data = cnt_q[31:0];
            WordTdr1:  rd_data = cnt_q[63:32];
            WordTcmp0: rd_data = cmp_q[31:0];
            WordTcmp1: rd_data = cmp_q[63:32];
            WordTier:  rd_data = {31'h0, int_en_q};
            WordTisr:  rd_data = {31'h0, int_st_q};
            WordThcsr: rd_data = thcsr_rd;
            default:   rd_data = 32'h0;
        endcase
        tim_prdata = rd_en ? rd_data : 32'h0;
    end

    assign tim_int = tim_int_q;

endmodule

// File: tb/tb_timer_regs.sv
// Bench for timer_regs: reset/register vector table, directed multi-cycle sequences and
// randomized accesses checked against a cycle-level behavioural model.
module tb_timer_regs;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [11:0] tim_paddr = '0;
    logic [31:0] tim_pwdata = '0;
    logic [3:0]  tim_pstrb = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        dbg_mode = 1'b0;
    logic [31:0] tim_prdata;
    logic        reg_error_flag;
    logic        tim_int;

    int n_checks = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    timer_regs dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .tim_paddr      (tim_paddr),
        .tim_pwdata     (tim_pwdata),
        .tim_pstrb      (tim_pstrb),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .dbg_mode       (dbg_mode),
        .tim_prdata     (tim_prdata),
        .reg_error_flag (reg_error_flag),
        .tim_int        (tim_int)
    );

    // Behavioural model state
    logic [63:0] m_cnt, m_cmp;
    int unsigned m_pre;
    logic        m_ten, m_den, m_ien, m_ist, m_int, m_hreq, m_hack;
    logic [3:0]  m_dval;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cnt = '0; m_cmp = '1; m_pre = 0;
        m_ten = 0; m_den = 0; m_dval = 4'd1;
        m_ien = 0; m_ist = 0; m_int = 0; m_hreq = 0; m_hack = 0;
    endtask

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_tcr();
        return {20'h0, m_dval, 6'h0, m_den, m_ten};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a[11:2])
            10'd0: return m_tcr();
            10'd1: return m_cnt[31:0];
            10'd2: return m_cnt[63:32];
            10'd3: return m_cmp[31:0];
            10'd4: return m_cmp[63:32];
            10'd5: return {31'h0, m_ien};
            10'd6: return {31'h0, m_ist};
`ifdef TIMER_HALT_EN
            10'd7: return {30'h0, m_hack, m_hreq};
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_error(input bit wr, input logic [11:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
        logic [31:0] t;
        if (!wr || a[11:2] != 10'd0) return 1'b0;
        t = m_merge(m_tcr(), d, s);
        return (t[11:8] > 4'd8) || (m_ten && (t[1] != m_den || t[11:8] != m_dval));
    endfunction

    // One clock edge of the model, from the state and inputs of the cycle before it
    task automatic m_step(input bit wr, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic dbg);
        logic [31:0] t;
        bit we, halted, n_ist, n_int, n_hack;
        int unsigned period;
        t = m_merge(m_tcr(), d, s);
        we = wr && !m_error(wr, a, d, s);
        halted = m_hack;
        n_ist = (m_cnt == m_cmp) || (m_ist && !(we && a[11:2] == 10'd6 && s[0] && d[0]));
        n_int = m_ist && m_ien;
        n_hack = dbg && m_hreq;
        if (we && a[11:2] == 10'd0 && m_ten && !t[0]) begin
            m_cnt = '0; m_pre = 0;
        end else if (we && a[11:2] == 10'd1) begin
            m_cnt[31:0] = m_merge(m_cnt[31:0], d, s); m_pre = 0;
        end else if (we && a[11:2] == 10'd2) begin
            m_cnt[63:32] = m_merge(m_cnt[63:32], d, s); m_pre = 0;
        end else if (m_ten && !halted) begin
            period = m_den ? (32'd1 << m_dval) : 32'd1;
            m_pre++;
            if (m_pre >= period) begin
                m_cnt = m_cnt + 64'd1;
                m_pre = 0;
            end
        end
        if (we) begin
            case (a[11:2])
                10'd0: begin m_ten = t[0]; m_den = t[1]; m_dval = t[11:8]; end
                10'd3: m_cmp[31:0] = m_merge(m_cmp[31:0], d, s);
                10'd4: m_cmp[63:32] = m_merge(m_cmp[63:32], d, s);
                10'd5: if (s[0]) m_ien = d[0];
`ifdef TIMER_HALT_EN
                10'd7: if (s[0]) m_hreq = d[0];
`endif
                default: ;
            endcase
        end
        m_ist = n_ist;
        m_int = n_int;
`ifdef TIMER_HALT_EN
        m_hack = n_hack;
`else
        m_hack = 1'b0;
`endif
    endtask

    // One access cycle: drive at negedge, sample comb outputs mid-low, step model at posedge
    task automatic cyc(input bit wr, input bit rd, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rdata, output logic err,
                       output logic intr);
        @(negedge sys_clk);
        wr_en = wr; rd_en = rd; tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
        #2;
        rdata = tim_prdata;
        err = reg_error_flag;
        check("prdata_model", 64'(rdata), 64'(rd ? m_read(a) : 32'h0));
        check("err_model", 64'(err), 64'(m_error(wr, a, d, s)));
        @(posedge sys_clk);
        m_step(wr, a, d, s, dbg_mode);
        #1;
        intr = tim_int;
        check("int_model", 64'(intr), 64'(m_int));
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    function automatic vec_t v(input bit wr, input bit rd, input logic [11:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               input logic [31:0] exp_rd, input bit exp_err);
        vec_t t;
        t.wr = wr; t.rd = rd; t.a = a; t.d = d; t.s = s; t.exp_rd = exp_rd; t.exp_err = exp_err;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] r;
        logic        e, ir;
        int          op, wsel;
        logic [11:0] ra;
        logic [31:0] rdat;
        logic [3:0]  rs;

        m_reset();
        repeat (3) @(negedge sys_clk);
        check("rst_prdata", 64'(tim_prdata), 64'h0);
        check("rst_err", 64'(reg_error_flag), 64'h0);
        check("rst_int", 64'(tim_int), 64'h0);
        #2 sys_rst_n = 1'b1;

        tbl.push_back(v(0, 1, 12'h000, 32'h0, 4'h0, 32'h0000_0100, 0));
        tbl.push_back(v(0, 1, 12'h004, 32'h0, 4'h0, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h008, 32'h0, 4'h0, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h00C, 32'h0, 4'h0, 32'hFFFF_FFFF, 0));
        tbl.push_back(v(0, 1, 12'h010, 32'h0, 4'h0, 32'hFFFF_FFFF, 0));
        tbl.push_back(v(0, 1, 12'h014, 32'h0, 4'h0, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h018, 32'h0, 4'h0, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h01C, 32'h0, 4'h0, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h020, 32'h0, 4'h0, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h803, 32'h0, 4'h0, 32'h0, 0));
        tbl.push_back(v(1, 0, 12'h00C, 32'hAABB_CCDD, 4'h1, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h00E, 32'h0, 4'h0, 32'hFFFF_FFDD, 0));
        tbl.push_back(v(1, 0, 12'h00C, 32'h0, 4'h0, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h00C, 32'h0, 4'h0, 32'hFFFF_FFDD, 0));
        tbl.push_back(v(1, 0, 12'h000, 32'h0000_0900, 4'h2, 32'h0, 1));
        tbl.push_back(v(0, 1, 12'h000, 32'h0, 4'h0, 32'h0000_0100, 0));
        tbl.push_back(v(1, 0, 12'h800, 32'hFFFF_FFFF, 4'hF, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h000, 32'h0, 4'h0, 32'h0000_0100, 0));
        tbl.push_back(v(1, 0, 12'h000, 32'h0000_0800, 4'h2, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h000, 32'h0, 4'h0, 32'h0000_0800, 0));
        tbl.push_back(v(1, 0, 12'h000, 32'hFFFF_F1FC, 4'hF, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h000, 32'h0, 4'h0, 32'h0000_0100, 0));
        tbl.push_back(v(1, 0, 12'h014, 32'hFFFF_FFFF, 4'h1, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h014, 32'h0, 4'h0, 32'h1, 0));
        tbl.push_back(v(1, 0, 12'h014, 32'h0, 4'h1, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h014, 32'h0, 4'h0, 32'h0, 0));
        tbl.push_back(v(0, 0, 12'h00C, 32'h0, 4'h0, 32'h0, 0));
        tbl.push_back(v(1, 0, 12'h00C, 32'hFFFF_FFFF, 4'hF, 32'h0, 0));
        tbl.push_back(v(0, 1, 12'h00C, 32'h0, 4'h0, 32'hFFFF_FFFF, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].s, r, e, ir);
            check($sformatf("vec%0d_rd", i), 64'(r), 64'(tbl[i].exp_rd));
            check($sformatf("vec%0d_err", i), 64'(e), 64'(tbl[i].exp_err));
        end

        // Prescaler: div_val=3 gives one increment per 8 cycles
        cyc(1, 0, 12'h000, 32'h0000_0303, 4'hF, r, e, ir);
        check("div_en_err", 64'(e), 64'h0);
        for (int k = 1; k <= 24; k++) begin
            cyc(0, 1, 12'h004, 32'h0, 4'h0, r, e, ir);
            check($sformatf("div_cnt%0d", k), 64'(r), 64'((k - 1) / 8));
        end
        cyc(1, 0, 12'h000, 32'h0000_0403, 4'hF, r, e, ir);
        check("div_change_err", 64'(e), 64'h1);
        cyc(0, 1, 12'h000, 32'h0, 4'h0, r, e, ir);
        check("div_change_tcr", 64'(r), 64'h303);
        cyc(1, 0, 12'h000, 32'h0000_0302, 4'hF, r, e, ir);
        check("disable_err", 64'(e), 64'h0);
        cyc(0, 1, 12'h004, 32'h0, 4'h0, r, e, ir);
        check("disable_clr", 64'(r), 64'h0);
        cyc(1, 0, 12'h000, 32'h0000_0100, 4'hF, r, e, ir);

        // 64-bit wrap
        cyc(1, 0, 12'h008, 32'hFFFF_FFFF, 4'hF, r, e, ir);
        cyc(1, 0, 12'h004, 32'hFFFF_FFFE, 4'hF, r, e, ir);
        cyc(1, 0, 12'h000, 32'h0000_0101, 4'hF, r, e, ir);
        check("wrap_en_err", 64'(e), 64'h0);
        cyc(0, 1, 12'h004, 32'h0, 4'h0, r, e, ir);
        check("wrap_c0", 64'(r), 64'hFFFF_FFFE);
        cyc(0, 1, 12'h004, 32'h0, 4'h0, r, e, ir);
        check("wrap_c1", 64'(r), 64'hFFFF_FFFF);
        cyc(0, 1, 12'h008, 32'h0, 4'h0, r, e, ir);
        check("wrap_hi", 64'(r), 64'h0);
        cyc(0, 1, 12'h004, 32'h0, 4'h0, r, e, ir);
        check("wrap_lo", 64'(r), 64'h1);
        check("wrap_noint", 64'(ir), 64'h0);
        cyc(1, 0, 12'h000, 32'h0000_0100, 4'hF, r, e, ir);

        // Interrupt latency, W1C and set-wins race
        cyc(1, 0, 12'h018, 32'h1, 4'h1, r, e, ir);
        cyc(1, 0, 12'h010, 32'h0, 4'hF, r, e, ir);
        cyc(1, 0, 12'h00C, 32'h10, 4'hF, r, e, ir);
        cyc(1, 0, 12'h014, 32'h1, 4'h1, r, e, ir);
        cyc(1, 0, 12'h000, 32'h0000_0101, 4'hF, r, e, ir);
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 1, 12'h018, 32'h0, 4'h0, r, e, ir);
            check($sformatf("isr%0d", k), 64'(r), 64'(k >= 18));
            check($sformatf("irq%0d", k), 64'(ir), 64'(k >= 18));
        end
        cyc(1, 0, 12'h018, 32'h1, 4'h1, r, e, ir);
        check("w1c_irq_lag", 64'(ir), 64'h1);
        cyc(0, 0, 12'h000, 32'h0, 4'h0, r, e, ir);
        check("w1c_irq_drop", 64'(ir), 64'h0);
        cyc(1, 0, 12'h000, 32'h0000_0100, 4'hF, r, e, ir);
        cyc(1, 0, 12'h004, 32'h10, 4'hF, r, e, ir);
        cyc(1, 0, 12'h018, 32'h1, 4'h1, r, e, ir);
        cyc(0, 1, 12'h018, 32'h0, 4'h0, r, e, ir);
        check("set_wins", 64'(r), 64'h1);

`ifdef TIMER_HALT_EN
        cyc(1, 0, 12'h01C, 32'h1, 4'h1, r, e, ir);
        cyc(1, 0, 12'h000, 32'h0000_0101, 4'hF, r, e, ir);
        repeat (3) cyc(0, 0, 12'h000, 32'h0, 4'h0, r, e, ir);
        dbg_mode = 1'b1;
        cyc(0, 0, 12'h000, 32'h0, 4'h0, r, e, ir);
        cyc(0, 1, 12'h01C, 32'h0, 4'h0, r, e, ir);
        check("halt_ack", 64'(r), 64'h3);
        cyc(0, 1, 12'h004, 32'h0, 4'h0, r, e, ir);
        check("halt_hold0", 64'(r), 64'h14);
        cyc(0, 1, 12'h004, 32'h0, 4'h0, r, e, ir);
        check("halt_hold1", 64'(r), 64'h14);
        dbg_mode = 1'b0;
        cyc(0, 0, 12'h000, 32'h0, 4'h0, r, e, ir);
        cyc(0, 1, 12'h004, 32'h0, 4'h0, r, e, ir);
        check("halt_release", 64'(r), 64'h14);
        cyc(0, 1, 12'h004, 32'h0, 4'h0, r, e, ir);
        check("halt_resume", 64'(r), 64'h15);
        cyc(1, 0, 12'h000, 32'h0000_0100, 4'hF, r, e, ir);
        cyc(1, 0, 12'h01C, 32'h0, 4'h1, r, e, ir);
`endif

        // Asynchronous reset in the middle of counting
        cyc(1, 0, 12'h000, 32'h0000_0101, 4'hF, r, e, ir);
        repeat (5) cyc(0, 0, 12'h000, 32'h0, 4'h0, r, e, ir);
        #2 sys_rst_n = 1'b0;
        m_reset();
        rd_en = 1'b1; tim_paddr = 12'h004;
        #1;
        check("async_rst_cnt", 64'(tim_prdata), 64'h0);
        check("async_rst_int", 64'(tim_int), 64'h0);
        rd_en = 1'b0;
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        cyc(0, 1, 12'h000, 32'h0, 4'h0, r, e, ir);
        check("post_rst_tcr", 64'(r), 64'h100);
        cyc(0, 1, 12'h004, 32'h0, 4'h0, r, e, ir);
        check("post_rst_cnt", 64'(r), 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            op = int'($urandom_range(0, 3));
            wsel = int'($urandom_range(0, 9));
            ra = 12'(wsel * 4 + int'($urandom_range(0, 3)));
            rs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (wsel)
                0: rdat = {20'h0, 4'($urandom_range(0, 9)), 6'($urandom), 1'($urandom),
                           1'($urandom_range(0, 3) != 0)};
                1: rdat = $urandom_range(0, 48);
                2: rdat = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
                3: rdat = $urandom_range(0, 64);
                4: rdat = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
                default: rdat = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) dbg_mode = ~dbg_mode;
            cyc(op == 2, op == 1 || op == 3, ra, rdat, rs, r, e, ir);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
